round_ctrl: RTL and testbench
=============================

Name: round_ctrl

Overview:
Game-round sequencer for the LED hit game. It requests a new random target from the LED randomizer and latches the one-hot LED it returns. It then times the hit window, judges button presses as hit or miss, and keeps score and lives. It sits between the randomizer (driving its freq input), the debounced button pulses, and the board LEDs and score display.

Parameters:
NUM_LEDS, 8, LED/button count; target and button vectors are this wide.
WINDOW_INIT, 1000, initial hit window in ticks.
WINDOW_MIN, 200, window floor in ticks.
WINDOW_STEP, 50, window reduction per hit.
GAP_TICKS, 250, LEDs-off gap between rounds, in ticks.
LIVES_INIT, 3, lives at game start (max 7).
SCORE_W, 8, score width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse: begin or restart a game
tick  in  1  one-cycle timebase strobe (1 ms)
btn_press  in  NUM_LEDS  one-cycle pulse per debounced button press
led_num  in  NUM_LEDS  one-hot target from randomizer
target_req  out  1  one-cycle pulse to randomizer freq input
led_out  out  NUM_LEDS  LEDs to board
score  out  SCORE_W  hits this game
lives  out  3  remaining lives
game_over  out  1  high in OVER state
state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst=0, async): state=IDLE, target_req=0, led_out=0, score=0, lives=LIVES_INIT, game_over=0, window=WINDOW_INIT, target=0.
- All outputs are registered.
- IDLE: LEDs off. A start pulse moves to REQ.
- REQ (1 cycle): target_req=1, then go to LOAD.
- LOAD (1 cycle): led_num settles. On the edge leaving LOAD, latch led_num into target.
  - Latched value not one-hot (including 0, since the randomizer output has no reset): go back to REQ (retry, no penalty).
  - Otherwise: go to ARMED and load timer=window.
- ARMED: led_out=target. Timer decrements on each tick.
  - Hit: btn_press has the target bit and no other bit set.
  - Miss: any non-target bit set, including a simultaneous correct+wrong press.
  - Expiry: tick while timer==1 is a miss.
  - Correct press in the same cycle as the expiring tick counts as a hit.
  - Presses with a zero vector are ignored.
- HIT (1 cycle):
  - score+1, saturating at all-ones.
  - window = max(window-WINDOW_STEP, WINDOW_MIN); no underflow.
  - Go to GAP.
- MISS (1 cycle): lives-1. If the result is 0, go to OVER; otherwise go to GAP.
- GAP: led_out=0 for GAP_TICKS ticks, then go to REQ. The start pulse is ignored here and in all in-game states.
- OVER: game_over=1, led_out=all ones, score and lives held. A start pulse clears score, sets lives=LIVES_INIT and window=WINDOW_INIT, and goes to REQ.
- Press handling: btn_press is ignored outside ARMED. There is no buffering of presses.
- Reset mid-game: immediate return to the reset values in any state.
- Latency: start to target_req is 1 cycle; target_req to LEDs lit is 2 cycles.

Optional Feature:
BONUS_LIFE_EN:
- Defined: every 10th consecutive hit (streak counter, cleared on miss and on new game) awards +1 life, saturating at 7, applied in the HIT cycle.
- Undefined: no streak counter, and lives only decrement.

Decomposition:
- Package round_pkg holds:
  - state enum: IDLE, REQ, LOAD, ARMED, HIT, MISS, GAP, OVER (3-bit, encoding exported on state_dbg).
  - tick-counter width constant, sized from max(WINDOW_INIT, GAP_TICKS).
  - BONUS_STREAK=10.
- One sub-module, round_timer: loadable down-counter advanced by tick, with an expire flag. It is shared between the ARMED window and the GAP delay.

Test Plan:
- Start; led_num=8'b00000100 after req; press btn=8'b00000100 before expiry -> target_req pulses once, led_out=00000100 two cycles after req, score=1, next window=950.
- No press for 1000 ticks in ARMED -> MISS, lives 3->2, GAP 250 ticks with led_out=0, then new target_req.
- led_num=0 at LOAD (randomizer unloaded) -> second target_req 2 cycles later, lives unchanged.
- Correct and wrong bits pressed together (btn=00000101, target=00000001) -> miss; separately, correct press in the same cycle as the final tick -> hit.
- Three misses -> game_over=1, led_out=8'hFF; start -> score=0, lives=3, window=1000; 20 hits -> window clamps at 200, score=20.
- BONUS_LIFE_EN: 10 consecutive hits with lives=2 -> lives=3. Reset asserted in ARMED -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/round_pkg.sv
// Shared types and constants for the LED hit game round sequencer.
// State encoding here is exported on state_dbg.
package round_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      LOAD  = 3'd2,
      ARMED = 3'd3,
      HIT   = 3'd4,
      MISS  = 3'd5,
      GAP   = 3'd6,
      OVER  = 3'd7
   } state_e;

   // Consecutive hits needed for a bonus life
   localparam int BONUS_STREAK = 10;

   // Bits needed to hold the larger of two tick counts
   function automatic int tick_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

   // Counter width for the default window and gap lengths
   localparam int TICK_W = tick_w(1000, 250);

endpackage

// File: rtl/round_timer.sv
// Loadable tick down-counter shared by the hit window and the gap delay.
// expire flags the tick that takes the count from 1 to 0.
module round_timer
   import round_pkg::*;
#(
   parameter int W = TICK_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         tick,
   output logic         expire
);

   logic [W-1:0] count;

   assign expire = en && tick && (count == W'(1));

   // Load has priority; otherwise count down one step per tick while enabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && tick && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer for the LED hit game: target fetch, hit window, score, lives.
// Optional BONUS_LIFE_EN: every 10th consecutive hit awards one life (max 7).
module round_ctrl
   import round_pkg::*;
#(
   parameter int NUM_LEDS    = 8,
   parameter int WINDOW_INIT = 1000,
   parameter int WINDOW_MIN  = 200,
   parameter int WINDOW_STEP = 50,
   parameter int GAP_TICKS   = 250,
   parameter int LIVES_INIT  = 3,
   parameter int SCORE_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                tick,
   input  logic [NUM_LEDS-1:0] btn_press,
   input  logic [NUM_LEDS-1:0] led_num,
   output logic                target_req,
   output logic [NUM_LEDS-1:0] led_out,
   output logic [SCORE_W-1:0]  score,
   output logic [2:0]          lives,
   output logic                game_over,
   output logic [2:0]          state_dbg
);

   localparam int TW = tick_w(WINDOW_INIT, GAP_TICKS);

   localparam logic [TW-1:0] WIN_INIT = TW'(WINDOW_INIT);
   localparam logic [TW-1:0] WIN_MIN  = TW'(WINDOW_MIN);
   localparam logic [TW-1:0] WIN_STEP = TW'(WINDOW_STEP);
   localparam logic [TW-1:0] GAP_LEN  = TW'(GAP_TICKS);
   localparam logic [2:0]    LIV_INIT = 3'(LIVES_INIT);

   state_e              state;
   logic [NUM_LEDS-1:0] target;
   logic [TW-1:0]       window;
   logic [TW-1:0]       win_next;
   logic [SCORE_W-1:0]  score_next;

   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_en;
   logic          expire;

   logic one_hot;
   logic hit;
   logic wrong;

`ifdef BONUS_LIFE_EN
   logic [3:0] streak;
`endif

   assign state_dbg = state;

   // Press judgement and next-value arithmetic
   always_comb begin
      one_hot    = $onehot(led_num);
      hit        = (btn_press == target);
      wrong      = |(btn_press & ~target);
      score_next = (&score) ? score : score + SCORE_W'(1);
      if ({1'b0, window} >= ({1'b0, WIN_MIN} + {1'b0, WIN_STEP})) begin
         win_next = window - WIN_STEP;
      end else begin
         win_next = WIN_MIN;
      end
   end

   // Timer control: window on arming, gap length after a judged round
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = window;
      tmr_en   = (state == ARMED) || (state == GAP);
      unique case (state)
         LOAD: begin
            tmr_load = one_hot;
            tmr_val  = window;
         end
         HIT, MISS: begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LEN;
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   round_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .tick     (tick),
      .expire   (expire)
   );

   // Round state machine with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         target_req <= 1'b0;
         led_out    <= '0;
         score      <= '0;
         lives      <= LIV_INIT;
         game_over  <= 1'b0;
         window     <= WIN_INIT;
         target     <= '0;
`ifdef BONUS_LIFE_EN
         streak     <= '0;
`endif
      end else begin
         target_req <= 1'b0;
         unique case (state)
            IDLE: begin
               led_out <= '0;
               if (start) begin
                  state      <= REQ;
                  target_req <= 1'b1;
               end
            end
            REQ: begin
               state <= LOAD;
            end
            LOAD: begin
               target <= led_num;
               if (one_hot) begin
                  state   <= ARMED;
                  led_out <= led_num;
               end else begin
                  state      <= REQ;
                  target_req <= 1'b1;
               end
            end
            ARMED: begin
               if (wrong) begin
                  state   <= MISS;
                  led_out <= '0;
               end else if (hit) begin
                  state   <= HIT;
                  led_out <= '0;
               end else if (expire) begin
                  state   <= MISS;
                  led_out <= '0;
               end
            end
            HIT: begin
               score  <= score_next;
               window <= win_next;
               state  <= GAP;
`ifdef BONUS_LIFE_EN
               if (streak == 4'(BONUS_STREAK - 1)) begin
                  streak <= '0;
                  if (lives != 3'd7) begin
                     lives <= lives + 3'd1;
                  end
               end else begin
                  streak <= streak + 4'd1;
               end
`endif
            end
            MISS: begin
               lives <= lives - 3'd1;
`ifdef BONUS_LIFE_EN
               streak <= '0;
`endif
               if (lives == 3'd1) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                  led_out   <= '1;
               end else begin
                  state <= GAP;
               end
            end
            GAP: begin
               if (expire) begin
                  state      <= REQ;
                  target_req <= 1'b1;
               end
            end
            OVER: begin
               if (start) begin
                  state      <= REQ;
                  target_req <= 1'b1;
                  game_over  <= 1'b0;
                  led_out    <= '0;
                  score      <= '0;
                  lives      <= LIV_INIT;
                  window     <= WIN_INIT;
`ifdef BONUS_LIFE_EN
                  streak     <= '0;
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: game-level model plus directed rounds.
// Ticks arrive every second cycle.
module tb_round_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       tick = 1'b0;
   logic [7:0] btn_press = '0;
   logic [7:0] led_num = '0;
   logic       target_req;
   logic [7:0] led_out;
   logic [7:0] score;
   logic [2:0] lives;
   logic       game_over;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;
   bit tick_en = 1'b0;
   bit cmp_on = 1'b0;

   // Game model: phase numbers follow the state list order 0..7
   int         m_ph = 0;
   int         m_left = 0;
   int         m_score = 0;
   int         m_lives = 3;
   int         m_win = 1000;
   int         m_streak = 0;
   logic [7:0] m_tgt = '0;

   round_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .tick       (tick),
      .btn_press  (btn_press),
      .led_num    (led_num),
      .target_req (target_req),
      .led_out    (led_out),
      .score      (score),
      .lives      (lives),
      .game_over  (game_over),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model of one game step per clock
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph = 0; m_left = 0; m_score = 0; m_lives = 3;
         m_win = 1000; m_streak = 0; m_tgt = '0;
      end else begin
         case (m_ph)
            0: if (start) m_ph = 1;
            1: m_ph = 2;
            2: begin
               m_tgt = led_num;
               if ($countones(led_num) == 1) begin
                  m_ph = 3;
                  m_left = m_win;
               end else m_ph = 1;
            end
            3: begin
               if ((btn_press & ~m_tgt) != 0) m_ph = 5;
               else if (btn_press == m_tgt) m_ph = 4;
               else if (tick && m_left == 1) m_ph = 5;
               else if (tick) m_left--;
            end
            4: begin
               m_score = (m_score < 255) ? m_score + 1 : 255;
               m_win = (m_win - 50 < 200) ? 200 : m_win - 50;
`ifdef BONUS_LIFE_EN
               m_streak++;
               if (m_streak == 10) begin
                  m_streak = 0;
                  if (m_lives < 7) m_lives++;
               end
`endif
               m_ph = 6;
               m_left = 250;
            end
            5: begin
               m_lives--;
               m_streak = 0;
               m_ph = (m_lives == 0) ? 7 : 6;
               m_left = 250;
            end
            6: if (tick) begin
               if (m_left == 1) m_ph = 1;
               else m_left--;
            end
            default: if (start) begin
               m_score = 0; m_lives = 3; m_win = 1000;
               m_streak = 0; m_ph = 1;
            end
         endcase
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("target_req", 32'(target_req), 32'(m_ph == 1));
         chk("led_out", 32'(led_out),
             (m_ph == 3) ? 32'(m_tgt) : ((m_ph == 7) ? 32'hFF : 32'h0));
         chk("score", 32'(score), 32'(m_score));
         chk("lives", 32'(lives), 32'(m_lives));
         chk("game_over", 32'(game_over), 32'(m_ph == 7));
         chk("state_dbg", 32'(state_dbg), 32'(m_ph));
      end
   end

   task automatic cyc();
      @(negedge clk);
      start = 1'b0;
      btn_press = '0;
      tick = tick_en ? ~tick : 1'b0;
   endtask

   task automatic wait_ph(input int p, input int budget);
      int n = 0;
      while (m_ph != p && n < budget) begin
         cyc();
         n++;
      end
      checks++;
      if (m_ph != p) begin
         errors++;
         $display("FAIL wait_phase%0d timeout at phase %0d", p, m_ph);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      bit found;
      repeat (3) cyc();
      chk("rst state", 32'(state_dbg), 0);
      chk("rst lives", 32'(lives), 3);
      chk("rst score", 32'(score), 0);
      chk("rst led", 32'(led_out), 0);
      chk("rst req", 32'(target_req), 0);
      chk("rst over", 32'(game_over), 0);
      rst = 1'b1;
      cmp_on = 1'b1;
      tick_en = 1'b1;
      led_num = 8'h04;

      // First round: req timing, lit target, hit
      cyc(); start = 1'b1;
      cyc(); chk("req after start", 32'(target_req), 1);
      cyc(); chk("req single pulse", 32'(target_req), 0);
      cyc(); chk("led two after req", 32'(led_out), 32'h04);
      repeat (5) cyc();
      btn_press = 8'h04;
      cyc(); cyc();
      chk("score first hit", 32'(score), 1);
      chk("model window 950", 32'(m_win), 950);

      // Let the window expire
      wait_ph(3, 1000);
      wait_ph(5, 2100);
      wait_ph(6, 5);
      chk("lives after expiry", 32'(lives), 2);
      wait_ph(1, 600);

      // Unloaded randomizer retries without penalty
      led_num = 8'h00;
      cyc(); cyc();
      chk("retry req", 32'(target_req), 1);
      chk("retry lives", 32'(lives), 2);
      led_num = 8'h01;
      cyc(); cyc();
      chk("retry lit", 32'(led_out), 32'h01);

      // Correct plus wrong bit is a miss
      btn_press = 8'h05;
      cyc(); cyc();
      chk("combo miss lives", 32'(lives), 1);

      // Correct press on the expiring tick is a hit
      wait_ph(3, 600);
      found = 1'b0;
      for (int n = 0; n < 2100 && !found; n++) begin
         cyc();
         if (m_ph == 3 && tick && m_left == 1) begin
            btn_press = m_tgt;
            found = 1'b1;
         end
      end
      chk("final tick reached", 32'(found), 1);
      cyc(); cyc();
      chk("final tick hit score", 32'(score), 2);

      // Last life lost
      wait_ph(3, 600);
      btn_press = 8'h80;
      wait_ph(7, 5);
      chk("over flag", 32'(game_over), 1);
      chk("over leds", 32'(led_out), 32'hFF);
      chk("over score held", 32'(score), 2);

      // Restart from OVER
      cyc(); start = 1'b1;
      cyc();
      chk("restart req", 32'(target_req), 1);
      chk("restart score", 32'(score), 0);
      chk("restart lives", 32'(lives), 3);
      chk("model window reset", 32'(m_win), 1000);

      // Twenty hits: window clamps at the floor
      for (int i = 0; i < 20; i++) begin
         led_num = 8'(1 << (i % 8));
         wait_ph(3, 600);
         btn_press = led_num;
         wait_ph(6, 5);
         if (i == 3) start = 1'b1;
      end
      chk("score 20", 32'(score), 20);
      chk("model window floor", 32'(m_win), 200);
`ifdef BONUS_LIFE_EN
      chk("bonus lives", 32'(lives), 5);
`else
      chk("no bonus lives", 32'(lives), 3);
`endif

      // Asynchronous reset while armed
      wait_ph(3, 600);
      #2 rst = 1'b0;
      #1;
      chk("async rst state", 32'(state_dbg), 0);
      chk("async rst led", 32'(led_out), 0);
      chk("async rst score", 32'(score), 0);
      chk("async rst lives", 32'(lives), 3);
      chk("async rst req", 32'(target_req), 0);
      chk("async rst over", 32'(game_over), 0);
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
